alu_frame_rx: RTL and testbench
===============================

# alu_frame_rx

Command-frame parser between the UART receiver's byte stream and the ALU execution core. Consumes bytes over a valid/ready handshake, decodes the 4-byte header (opcode, reserved, 16-bit little-endian length) and validates opcode and length. Repacks the payload into 32-bit little-endian words tagged with opcode, first/last and byte count. Illegal frames are consumed and dropped, with a one-cycle error pulse.

## Interface
- `MaxLen`, default 16'd1024: largest legal total frame length in bytes, header included.
- `clk_i` in 1: sole clock, rising edge.
- `reset_i` in 1: synchronous, active-high reset.
- `valid_i` in 1: input byte valid (from UART receiver).
- `data_i` in 8: input byte.
- `ready_o` out 1: parser accepts the byte this cycle.
- `valid_o` out 1: output word valid.
- `word_o` out 32: payload word, little-endian; the first payload byte is in [7:0].
- `bytes_o` out 3: number of valid bytes in `word_o`, 1–4. Unused upper bytes are zero.
- `opcode_o` out 8: opcode of the frame the word belongs to.
- `first_o` out 1: first word of the frame.
- `last_o` out 1: final word of the frame.
- `ready_i` in 1: downstream (ALU core) accepts the word.
- `err_o` out 1: one-cycle pulse when a frame is rejected.
- `err_code_o` out 2: meaningful only while `err_o` is high. 2'd1 = unknown opcode, 2'd2 = bad length.

## Operation
- States:
  - HDR: collect bytes 0–3.
  - PAYLOAD: forward the payload.
  - DROP: discard the payload of a rejected frame.
- A byte transfers when `valid_i && ready_o`.
- HDR:
  - Byte 0 = opcode, byte 1 = reserved (ignored), bytes 2/3 = `len` low/high.
  - Decision is made on the cycle byte 3 transfers. `rem` = `len`−4 is the number of payload bytes.
- Legal opcodes: ECHO 8'hEC, ADD 8'hA8, MUL 8'hB7, DIV 8'hD4.
- Length rules:
  - All opcodes: 4 ≤ `len` ≤ `MaxLen`.
  - ADD/MUL/DIV: additionally `len` = 12, i.e. exactly two operand words.
- Checks are applied in this order, first match wins:
  1. `len` < 4 → `err_o`, code 2, next state HDR. No payload is consumed; the next byte is treated as a new opcode.
  2. Unknown opcode → `err_o`, code 1, DROP with `rem`.
  3. Other length violation → `err_o`, code 2, DROP with `rem` (if `rem` = 0, go to HDR).
  4. Legal frame with `rem` = 0 (ECHO, `len` = 4) → HDR; no words are emitted.
  5. Otherwise → PAYLOAD.
- PAYLOAD:
  - Bytes are packed into a 4-byte assembler.
  - A word is emitted when 4 bytes are collected, or when `rem` reaches 0 on a partial word (`bytes_o` = count collected).
  - `first_o` is set on the first word of the frame. `last_o` is set on the word holding the final byte. After that word is emitted, go to HDR.
- DROP: `ready_o` is held 1 and bytes are counted down. When `rem` hits 0 → HDR. Nothing is emitted.
- `rem` is a 16-bit down-counter. It never wraps, because `len` ≥ 4 is checked before the subtraction.

## Timing
- Reset values:
  - `valid_o`=0, `err_o`=0, `ready_o`=1.
  - `word_o`, `bytes_o`, `opcode_o`, `first_o`, `last_o`, `err_code_o` = 0.
  - State HDR, assembler empty.
- Reset mid-frame discards all partial state. The next byte is parsed as an opcode.
- `ready_o`:
  - HDR and DROP: 1.
  - PAYLOAD: `!(valid_o && !ready_i)`.
- Output register: a single stage.
- Latency:
  - `valid_o` rises the cycle after the transfer of the word's final byte.
  - `err_o` pulses the cycle after header byte 3.
- Output stability: while `valid_o && !ready_i`, all output fields are held stable and no payload byte is accepted.
- Simultaneous pop and completion: if a word completes on the same cycle the held word is popped (`ready_i`=1), the new word loads and `valid_o` stays 1.
- Throughput: 1 byte/cycle with no stalls.
- Back-to-back frames: the next header byte may transfer on the cycle after the last payload byte.

## Structure
- Package `alu_frame_pkg`:
  - opcode localparams (ECHO/ADD/MUL/DIV);
  - error-code enum;
  - state enum;
  - header byte offsets;
  - operand-frame length constant 16'd12.
- Shared by the ALU core and the response framer.
- One natural sub-module: `byte_word_packer`, the 4-byte assembler plus output register with `bytes_o`/`last_o` tagging.
- The FSM, header decode and counters stay in the top level.

## Test plan
- ADD frame: A8 00 0C 00 01 00 00 00 02 00 00 00, `ready_i`=1. Expect 2 words:
  - 32'h1 with first=1, last=0, bytes=4;
  - 32'h2 with first=0, last=1, bytes=4;
  - `opcode_o`=8'hA8.
- ECHO frame: EC 00 07 00 61 62 63. Expect one word 32'h00636261 with bytes=3, first=last=1.
- Bad opcode: 55 00 06 00 AA BB, followed by a legal ECHO frame.
  - Expect one `err_o` pulse with code 1.
  - AA/BB are swallowed, no word is emitted, and the ECHO frame is parsed normally.
- Bad length: A8 00 08 00 + 4 bytes → code 2, 4 bytes dropped. Then EC 00 02 00 → code 2, immediate HDR.
- Backpressure: during the ADD frame, hold `ready_i`=0 for 10 cycles after the first word.
  - `ready_o` = 0 from the word's completion onward, and `word_o` stays stable.
  - After release, the same words are delivered with none lost.
- Reset mid-payload: assert `reset_i` after the 6th byte of an ADD frame.
  - All outputs return to reset values.
  - A following ECHO frame parses correctly.

Source files
------------

// File: rtl/alu_frame_pkg.sv
// rtl/alu_frame_pkg.sv - shared constants and types for the ALU command-frame path
// Contents: opcode values, header byte offsets, operand-frame length,
// error-code and parser-state enums, opcode classification helpers.
package alu_frame_pkg;

  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'hA8;
  localparam logic [7:0] OP_MUL  = 8'hB7;
  localparam logic [7:0] OP_DIV  = 8'hD4;

  localparam logic [1:0] HDR_OPCODE = 2'd0;
  localparam logic [1:0] HDR_RSVD   = 2'd1;
  localparam logic [1:0] HDR_LEN_LO = 2'd2;
  localparam logic [1:0] HDR_LEN_HI = 2'd3;

  localparam logic [15:0] HDR_LEN     = 16'd4;
  localparam logic [15:0] OPERAND_LEN = 16'd12;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_OPCODE = 2'd1,
    ERR_LENGTH = 2'd2
  } err_code_e;

  typedef enum logic [1:0] {
    ST_HDR     = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DROP    = 2'd2
  } state_e;

  function automatic logic is_known_opcode(input logic [7:0] op);
    return (op == OP_ECHO) || (op == OP_ADD) || (op == OP_MUL) || (op == OP_DIV);
  endfunction

  // Arithmetic opcodes carry exactly two 32-bit operands.
  function automatic logic is_operand_opcode(input logic [7:0] op);
    return (op == OP_ADD) || (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/byte_word_packer.sv
// rtl/byte_word_packer.sv - packs payload bytes into tagged 32-bit little-endian words
// Ports:
//   clk_i, reset_i             clock, synchronous active-high reset
//   byte_valid_i, byte_data_i  payload byte accepted this cycle
//   byte_last_i                this byte is the final payload byte of the frame
//   frame_start_i              a new frame's payload begins (arms first_o)
//   opcode_i                   opcode of the current frame
//   ready_i                    downstream pops the held word
//   valid_o, word_o, bytes_o, opcode_o, first_o, last_o   output word register
module byte_word_packer (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  input  logic        byte_last_i,
  input  logic        frame_start_i,
  input  logic [7:0]  opcode_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] word_o,
  output logic [2:0]  bytes_o,
  output logic [7:0]  opcode_o,
  output logic        first_o,
  output logic        last_o
);

  logic [23:0] acc_q;    // up to three pending bytes, byte 0 in [7:0]
  logic [1:0]  cnt_q;    // number of pending bytes
  logic        first_q;  // next emitted word is the first of its frame
  logic        complete;
  logic [31:0] word_next;

  // Caller only presents a byte when the output register can take a word,
  // so completion never has to wait.
  assign complete = byte_valid_i && ((cnt_q == 2'd3) || byte_last_i);

  // New byte lands above the pending ones; unused upper bytes are zero.
  always_comb begin
    word_next = 32'd0;
    case (cnt_q)
      2'd0:    word_next = {24'd0, byte_data_i};
      2'd1:    word_next = {16'd0, byte_data_i, acc_q[7:0]};
      2'd2:    word_next = {8'd0, byte_data_i, acc_q[15:0]};
      default: word_next = {byte_data_i, acc_q};
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      acc_q    <= 24'd0;
      cnt_q    <= 2'd0;
      first_q  <= 1'b0;
      valid_o  <= 1'b0;
      word_o   <= 32'd0;
      bytes_o  <= 3'd0;
      opcode_o <= 8'd0;
      first_o  <= 1'b0;
      last_o   <= 1'b0;
    end else begin
      if (frame_start_i) begin
        first_q <= 1'b1;
      end
      if (complete) begin
        acc_q    <= 24'd0;
        cnt_q    <= 2'd0;
        first_q  <= 1'b0;
        valid_o  <= 1'b1;
        word_o   <= word_next;
        bytes_o  <= {1'b0, cnt_q} + 3'd1;
        opcode_o <= opcode_i;
        first_o  <= first_q;
        last_o   <= byte_last_i;
      end else begin
        if (byte_valid_i) begin
          case (cnt_q)
            2'd0:    acc_q[7:0]   <= byte_data_i;
            2'd1:    acc_q[15:8]  <= byte_data_i;
            default: acc_q[23:16] <= byte_data_i;
          endcase
          cnt_q <= cnt_q + 2'd1;
        end
        if (ready_i) begin
          valid_o <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/alu_frame_rx.sv
// rtl/alu_frame_rx.sv - command-frame parser from UART byte stream to ALU word stream
// Ports:
//   clk_i, reset_i                  clock, synchronous active-high reset
//   valid_i, data_i, ready_o        input byte handshake
//   valid_o, word_o, bytes_o,
//   opcode_o, first_o, last_o,
//   ready_i                         output word handshake
//   err_o, err_code_o               one-cycle rejection pulse and its reason
module alu_frame_rx
  import alu_frame_pkg::*;
#(
  parameter logic [15:0] MaxLen = 16'd1024
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        valid_i,
  input  logic [7:0]  data_i,
  output logic        ready_o,
  output logic        valid_o,
  output logic [31:0] word_o,
  output logic [2:0]  bytes_o,
  output logic [7:0]  opcode_o,
  output logic        first_o,
  output logic        last_o,
  input  logic        ready_i,
  output logic        err_o,
  output logic [1:0]  err_code_o
);

  state_e      state_q;
  logic [1:0]  hdr_idx_q;
  logic [7:0]  opcode_q;
  logic [7:0]  len_lo_q;
  logic [15:0] rem_q;
  logic        err_q;
  err_code_e   err_code_q;

  logic        xfer;
  logic [15:0] len_w;
  logic [15:0] rem_w;
  state_e      dec_next;
  logic        dec_err;
  err_code_e   dec_code;
  logic        hdr_done;
  logic        pay_byte;

  // Only PAYLOAD can stall: a byte may complete a word, which needs a free
  // (or simultaneously popped) output register.
  assign ready_o  = (state_q != ST_PAYLOAD) || !(valid_o && !ready_i);
  assign xfer     = valid_i && ready_o;
  assign len_w    = {data_i, len_lo_q};
  assign rem_w    = len_w - HDR_LEN;
  assign hdr_done = xfer && (state_q == ST_HDR) && (hdr_idx_q == HDR_LEN_HI);
  assign pay_byte = xfer && (state_q == ST_PAYLOAD);

  // Header decision, evaluated while length byte 3 is on data_i.
  // Short length is tested first so no payload is ever consumed for it.
  always_comb begin
    dec_next = ST_HDR;
    dec_err  = 1'b0;
    dec_code = ERR_NONE;
    if (len_w < HDR_LEN) begin
      dec_err  = 1'b1;
      dec_code = ERR_LENGTH;
    end else if (!is_known_opcode(opcode_q)) begin
      dec_err  = 1'b1;
      dec_code = ERR_OPCODE;
      if (rem_w != 16'd0) dec_next = ST_DROP;
    end else if ((len_w > MaxLen) ||
                 (is_operand_opcode(opcode_q) && (len_w != OPERAND_LEN))) begin
      dec_err  = 1'b1;
      dec_code = ERR_LENGTH;
      if (rem_w != 16'd0) dec_next = ST_DROP;
    end else if (rem_w != 16'd0) begin
      dec_next = ST_PAYLOAD;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ST_HDR;
      hdr_idx_q  <= HDR_OPCODE;
      opcode_q   <= 8'd0;
      len_lo_q   <= 8'd0;
      rem_q      <= 16'd0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        ST_HDR: begin
          if (xfer) begin
            hdr_idx_q <= hdr_idx_q + 2'd1;
            case (hdr_idx_q)
              HDR_OPCODE: opcode_q <= data_i;
              HDR_LEN_LO: len_lo_q <= data_i;
              HDR_LEN_HI: begin
                state_q <= dec_next;
                if (dec_next != ST_HDR) rem_q <= rem_w;
                err_q <= dec_err;
                if (dec_err) err_code_q <= dec_code;
              end
              default: ;
            endcase
          end
        end
        ST_PAYLOAD, ST_DROP: begin
          if (xfer) begin
            rem_q <= rem_q - 16'd1;
            if (rem_q == 16'd1) state_q <= ST_HDR;
          end
        end
        default: state_q <= ST_HDR;
      endcase
    end
  end

  assign err_o      = err_q;
  assign err_code_o = err_code_q;

  byte_word_packer u_packer (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .byte_valid_i  (pay_byte),
    .byte_data_i   (data_i),
    .byte_last_i   (rem_q == 16'd1),
    .frame_start_i (hdr_done && (dec_next == ST_PAYLOAD)),
    .opcode_i      (opcode_q),
    .ready_i       (ready_i),
    .valid_o       (valid_o),
    .word_o        (word_o),
    .bytes_o       (bytes_o),
    .opcode_o      (opcode_o),
    .first_o       (first_o),
    .last_o        (last_o)
  );

endmodule

// File: tb/tb_alu_frame_rx.sv
// tb/tb_alu_frame_rx.sv - self-checking bench for alu_frame_rx
module tb_alu_frame_rx;

  localparam int MAX_LEN = 1024;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        valid_i;
  logic [7:0]  data_i;
  logic        ready_o;
  logic        valid_o;
  logic [31:0] word_o;
  logic [2:0]  bytes_o;
  logic [7:0]  opcode_o;
  logic        first_o;
  logic        last_o;
  logic        ready_i;
  logic        err_o;
  logic [1:0]  err_code_o;

  always #5 clk = ~clk;

  alu_frame_rx #(.MaxLen(16'd1024)) dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .valid_i    (valid_i),
    .data_i     (data_i),
    .ready_o    (ready_o),
    .valid_o    (valid_o),
    .word_o     (word_o),
    .bytes_o    (bytes_o),
    .opcode_o   (opcode_o),
    .first_o    (first_o),
    .last_o     (last_o),
    .ready_i    (ready_i),
    .err_o      (err_o),
    .err_code_o (err_code_o)
  );

  typedef logic [7:0] u8;
  typedef u8 u8_q_t[$];

  typedef struct {
    logic [31:0] w;
    logic [2:0]  b;
    logic [7:0]  op;
    logic        f;
    logic        l;
  } exp_word_t;

  typedef struct {
    logic [127:0] data;
    int           n;
    int           exp_words;
    logic [31:0]  exp_w0;
    logic [2:0]   exp_b0;
    int           exp_errs;
    logic [1:0]   exp_code;
  } vec_t;

  exp_word_t  exp_q[$];
  logic [1:0] exp_err_q[$];
  int errors = 0;
  int checks = 0;
  int words_seen = 0;
  int errs_seen = 0;
  logic        cap_armed = 1'b0;
  logic [31:0] cap_word;
  logic [2:0]  cap_bytes;
  logic [1:0]  last_err_code;
  int  rdy_mode = 0;  // 0: always ready, 1: random, 2: driven by the test
  bit  gap_en = 0;
  exp_word_t mon_e;
  logic [1:0] mon_c;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  // Behavioural reference: walks whole frames and lists the words and
  // errors the parser must produce.
  task automatic model_frames(input u8_q_t s);
    int i;
    int n;
    int len;
    int nb;
    logic [7:0]  op;
    logic [31:0] w;
    exp_word_t   e;
    i = 0;
    n = s.size();
    while (i + 4 <= n) begin
      op  = s[i];
      len = int'(s[i+2]) | (int'(s[i+3]) << 8);
      if (len < 4) begin
        exp_err_q.push_back(2'd2);
        i += 4;
      end else if (!(op inside {8'hEC, 8'hA8, 8'hB7, 8'hD4})) begin
        exp_err_q.push_back(2'd1);
        i += len;
      end else if (len > MAX_LEN || (op != 8'hEC && len != 12)) begin
        exp_err_q.push_back(2'd2);
        i += len;
      end else begin
        for (int p = 4; p < len; p += 4) begin
          nb = (len - p < 4) ? len - p : 4;
          w = 32'd0;
          for (int k = 0; k < nb; k++) w = w | (32'(s[i+p+k]) << (8*k));
          e.w  = w;
          e.b  = 3'(nb);
          e.op = op;
          e.f  = (p == 4);
          e.l  = (p + 4 >= len);
          exp_q.push_back(e);
        end
        i += len;
      end
    end
  endtask

  task automatic build_frame(input logic [7:0] op, input int len, output u8_q_t f);
    f = {};
    f.push_back(op);
    f.push_back(8'($urandom));
    f.push_back(8'(len));
    f.push_back(8'(len >> 8));
    if (len > 4)
      for (int k = 0; k < len - 4; k++) f.push_back(8'($urandom));
  endtask

  task automatic send_byte(input u8 b);
    bit done;
    int t;
    done = 0;
    t = 0;
    valid_i = 1'b1;
    data_i  = b;
    while (!done) begin
      @(negedge clk);
      if (ready_o) done = 1;
      else if (++t > 1000) begin
        errors++;
        checks++;
        $display("FAIL send_timeout: ready_o stuck at 0 for byte %0h", b);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    valid_i = 1'b0;
  endtask

  task automatic send_stream(input u8_q_t s);
    foreach (s[k]) begin
      if (gap_en && $urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send_byte(s[k]);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || exp_err_q.size() != 0) && t < 5000) begin
      @(posedge clk);
      t++;
    end
    chk("drain_pending", 64'(exp_q.size() + exp_err_q.size()), 64'd0);
    exp_q.delete();
    exp_err_q.delete();
    repeat (3) @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 1) ready_i = 1'($urandom_range(0, 1));
    else if (rdy_mode == 0) ready_i = 1'b1;
  end

  // Output monitor: a word transfers at the next edge when valid_o && ready_i.
  always @(negedge clk) begin
    if (!reset_i) begin
      if (valid_o && ready_i) begin
        words_seen++;
        if (cap_armed) begin
          cap_word  = word_o;
          cap_bytes = bytes_o;
          cap_armed = 1'b0;
        end
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %0h expected none", word_o);
        end else begin
          mon_e = exp_q.pop_front();
          chk("word", 64'(word_o), 64'(mon_e.w));
          chk("word_tags", {bytes_o, opcode_o, first_o, last_o},
              {mon_e.b, mon_e.op, mon_e.f, mon_e.l});
        end
      end
      if (err_o) begin
        errs_seen++;
        last_err_code = err_code_o;
        if (exp_err_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_err: got code %0d expected none", err_code_o);
        end else begin
          mon_c = exp_err_q.pop_front();
          chk("err_code", 64'(err_code_o), 64'(mon_c));
        end
      end
    end
  end

  initial begin
    #800000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  vec_t        vecs[9];
  u8_q_t       s;
  logic [127:0] d;
  int          w0;
  int          e0;
  logic [31:0] hold_w;
  int          t;
  logic [7:0]  op;
  int          len;
  int          kind;

  initial begin
    vecs[0] = '{data:128'hA8000C00_01000000_02000000, n:12, exp_words:2, exp_w0:32'h1,        exp_b0:3'd4, exp_errs:0, exp_code:2'd0};
    vecs[1] = '{data:128'hEC000700_616263,            n:7,  exp_words:1, exp_w0:32'h00636261, exp_b0:3'd3, exp_errs:0, exp_code:2'd0};
    vecs[2] = '{data:128'h55000600_AABB,              n:6,  exp_words:0, exp_w0:32'h0,        exp_b0:3'd0, exp_errs:1, exp_code:2'd1};
    vecs[3] = '{data:128'hEC000700_616263,            n:7,  exp_words:1, exp_w0:32'h00636261, exp_b0:3'd3, exp_errs:0, exp_code:2'd0};
    vecs[4] = '{data:128'hA8000800_11223344,          n:8,  exp_words:0, exp_w0:32'h0,        exp_b0:3'd0, exp_errs:1, exp_code:2'd2};
    vecs[5] = '{data:128'hEC000200,                   n:4,  exp_words:0, exp_w0:32'h0,        exp_b0:3'd0, exp_errs:1, exp_code:2'd2};
    vecs[6] = '{data:128'hEC000400,                   n:4,  exp_words:0, exp_w0:32'h0,        exp_b0:3'd0, exp_errs:0, exp_code:2'd0};
    vecs[7] = '{data:128'hB7000C00_AABBCCDD_01020304, n:12, exp_words:2, exp_w0:32'hDDCCBBAA, exp_b0:3'd4, exp_errs:0, exp_code:2'd0};
    vecs[8] = '{data:128'hEC000500_42,                n:5,  exp_words:1, exp_w0:32'h42,       exp_b0:3'd1, exp_errs:0, exp_code:2'd0};

    reset_i = 1'b1;
    valid_i = 1'b0;
    data_i  = 8'd0;
    ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset_i = 1'b0;

    @(negedge clk);
    chk("reset_outputs", {valid_o, err_o, ready_o, word_o, bytes_o, opcode_o, first_o, last_o, err_code_o},
        {1'b0, 1'b0, 1'b1, 32'd0, 3'd0, 8'd0, 1'b0, 1'b0, 2'd0});
    @(posedge clk);
    #1;

    // Table-driven frames from the test plan.
    rdy_mode = 0;
    foreach (vecs[v]) begin
      d = vecs[v].data;
      s = {};
      for (int i = 0; i < vecs[v].n; i++) s.push_back(d[(vecs[v].n - 1 - i) * 8 +: 8]);
      model_frames(s);
      w0 = words_seen;
      e0 = errs_seen;
      cap_armed = 1'b1;
      send_stream(s);
      drain();
      cap_armed = 1'b0;
      chk($sformatf("vec%0d_words", v), 64'(words_seen - w0), 64'(vecs[v].exp_words));
      chk($sformatf("vec%0d_errs", v), 64'(errs_seen - e0), 64'(vecs[v].exp_errs));
      if (vecs[v].exp_words > 0)
        chk($sformatf("vec%0d_first_word", v), {cap_bytes, cap_word}, {vecs[v].exp_b0, vecs[v].exp_w0});
      if (vecs[v].exp_errs > 0)
        chk($sformatf("vec%0d_code", v), 64'(last_err_code), 64'(vecs[v].exp_code));
    end

    // Backpressure: hold the first ADD word for 10 cycles.
    rdy_mode = 2;
    ready_i = 1'b0;
    s = {8'hA8, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
    model_frames(s);
    fork
      send_stream(s);
    join_none
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!valid_o && t < 100);
    chk("bp_valid_rise", 64'(valid_o), 64'd1);
    hold_w = word_o;
    chk("bp_first_word", 64'(word_o), 64'h1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_word_stable", 64'(word_o), 64'(hold_w));
      chk("bp_ready_low", {valid_o, ready_o}, 2'b10);
    end
    @(posedge clk);
    #1;
    ready_i = 1'b1;
    rdy_mode = 0;
    wait fork;
    drain();

    // Reset after the 6th byte of an ADD frame, then a clean ECHO frame.
    s = {8'hA8, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h06};
    send_stream(s);
    reset_i = 1'b1;
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    @(negedge clk);
    chk("midreset_outputs", {valid_o, err_o, ready_o, word_o, bytes_o, opcode_o, first_o, last_o, err_code_o},
        {1'b0, 1'b0, 1'b1, 32'd0, 3'd0, 8'd0, 1'b0, 1'b0, 2'd0});
    @(posedge clk);
    #1;
    s = {8'hEC, 8'h00, 8'h06, 8'h00, 8'h10, 8'h20};
    model_frames(s);
    w0 = words_seen;
    cap_armed = 1'b1;
    send_stream(s);
    drain();
    cap_armed = 1'b0;
    chk("midreset_echo_words", 64'(words_seen - w0), 64'd1);
    chk("midreset_echo_word", {cap_bytes, cap_word}, {3'd2, 32'h00002010});

    // Length boundaries around MaxLen, with random downstream stalls.
    rdy_mode = 1;
    gap_en = 1;
    build_frame(8'hEC, MAX_LEN, s);
    model_frames(s);
    w0 = words_seen;
    send_stream(s);
    drain();
    chk("maxlen_words", 64'(words_seen - w0), 64'((MAX_LEN - 4) / 4));
    build_frame(8'hEC, MAX_LEN + 1, s);
    model_frames(s);
    e0 = errs_seen;
    send_stream(s);
    drain();
    chk("maxlen_plus1_errs", 64'(errs_seen - e0), 64'd1);
    chk("maxlen_plus1_code", 64'(last_err_code), 64'd2);

    // Randomised frames against the reference model.
    for (int f = 0; f < 60; f++) begin
      kind = $urandom_range(0, 4);
      case (kind)
        0: begin op = 8'hEC; len = $urandom_range(4, 24); end
        1: begin
          case ($urandom_range(0, 2))
            0: op = 8'hA8;
            1: op = 8'hB7;
            default: op = 8'hD4;
          endcase
          len = 12;
        end
        2: begin
          do op = 8'($urandom); while (op inside {8'hEC, 8'hA8, 8'hB7, 8'hD4});
          len = $urandom_range(4, 20);
        end
        3: begin
          op = ($urandom_range(0, 1) == 0) ? 8'hA8 : 8'hD4;
          do len = $urandom_range(4, 20); while (len == 12);
        end
        default: begin op = 8'($urandom); len = $urandom_range(0, 3); end
      endcase
      build_frame(op, len, s);
      model_frames(s);
      send_stream(s);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
